shift_seq: RTL and testbench
============================

// Module: shift_seq
// PURPOSE
//  Multi-cycle shift sequencer for the RV32I SLL/SRL/SRA (and immediate) instructions.
//  Performs a shift of shamt bits as shamt single-bit steps on a working register,
//  which avoids a full barrel shifter. It sits beside the ALU and is started by the
//  control unit. It reports busy while stepping and pulses done when the result is final.
// PARAMETERS
//  N   32           datapath width in bits
//  SW  $clog2(N)    shift-amount width (5 for N=32); must satisfy 2**SW == N
// PORTS
//  clk      in   1    system clock, rising-edge
//  rst      in   1    asynchronous reset, active-high
//  start    in   1    request a shift; sampled on rising clk edge
//  op       in   2    00=SLL, 01=SRL, 11=SRA, 10=reserved (executes as SLL)
//  operand  in   N    value to shift; sampled with accepted start
//  shamt    in   SW   shift amount 0..N-1; sampled with accepted start
//  busy     out  1    1 while in SHIFT state
//  done     out  1    one-cycle pulse: result is final
//  result   out  N    working register contents
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, result=0, count=0, busy=0, done=0, latched op=00.
//   Reset mid-operation aborts the shift. No done is produced.
//  States: IDLE, SHIFT, DONE. busy=1 only in SHIFT. done=1 only in DONE.
//  Accepting start:
//   - start is accepted only in IDLE or DONE. start during SHIFT is ignored (not queued).
//   - On the accepting edge, the block latches op, loads result<=operand and count<=shamt.
//   - Next state is SHIFT if shamt!=0, else DONE.
//  SHIFT, each edge, one single-bit step:
//   - SLL: result <= {result[N-2:0],1'b0}
//   - SRL: result <= {1'b0,result[N-1:1]}
//   - SRA: result <= {result[N-1],result[N-1:1]}
//   - count <= count-1.
//   - When count==1 on that edge, next state is DONE, otherwise stay in SHIFT.
//  DONE, one cycle:
//   - With start=1, the new request is accepted (back-to-back).
//   - Otherwise go to IDLE.
//  Latency: start accepted in cycle 0 -> done=1 in cycle shamt+1 (shamt=0 -> cycle 1).
//   Throughput is one shift per shamt+1 cycles.
//  result:
//   - Shows partial values while busy.
//   - Stable from the done cycle until the next accepted start, including through IDLE.
//  Widths:
//   - count is SW bits and never wraps, because it is decremented only while >=1.
//   - shamt is unsigned. Values above N-1 are impossible by width.
//  Simultaneous start in DONE: done stays high for that cycle; the next cycle is SHIFT or DONE per the new shamt.
// TESTING
//  1 Assert rst mid-cycle (async) -> busy=0, done=0, result=0 immediately, without waiting for a clk edge.
//  2 SLL operand=32'h0000_0001, shamt=31 -> busy cycles 1..31, done in cycle 32, result=32'h8000_0000.
//  3 SRA operand=32'h8000_00F0, shamt=4 -> done in cycle 5, result=32'hF800_000F.
//    SRL on the same operand -> result=32'h0800_000F.
//  4 SRL operand=32'hDEAD_BEEF, shamt=0 -> busy never 1, done in cycle 1, result=32'hDEAD_BEEF.
//  5 start during SHIFT (SLL 1 by 3, then start with operand=0 at cycle 2) -> ignored; done at cycle 4, result=8.
//    Then start held in the DONE cycle (SRL 32'h10 by 4) -> accepted, done 5 cycles later, result=1.
//  6 rst pulse during SHIFT of a shamt=20 op -> IDLE, no done pulse.
//    A new start after rst deasserts completes normally.

Source files
------------

// File: rtl/shift_seq_if.sv
// Bundles the request and result signals of the shift sequencer.
// The master side (control unit) issues requests; the slave side is the sequencer.
interface shift_seq_if #(
   parameter int N  = 32,
   parameter int SW = $clog2(N)
);
   logic          start;
   logic [1:0]    op;
   logic [N-1:0]  operand;
   logic [SW-1:0] shamt;
   logic          busy;
   logic          done;
   logic [N-1:0]  result;

   modport master (
      output start, op, operand, shamt,
      input  busy, done, result
   );

   modport slave (
      input  start, op, operand, shamt,
      output busy, done, result
   );
endinterface

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer for RV32I SLL/SRL/SRA.
// A shift by shamt is carried out as shamt single-bit steps on a working
// register, so no barrel shifter is needed. busy marks the stepping phase and
// done pulses for one cycle when the result is final.
module shift_seq #(
   parameter int N  = 32,
   parameter int SW = $clog2(N)
) (
   input  logic       clk,
   input  logic       rst,
   shift_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b11;

   state_t        state_q, state_d;
   logic [N-1:0]  result_q, result_d;
   logic [SW-1:0] count_q, count_d;
   logic [1:0]    op_q, op_d;

   // State register plus the working register, step counter and latched op.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         result_q <= '0;
         count_q  <= '0;
         op_q     <= 2'b00;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         count_q  <= count_d;
         op_q     <= op_d;
      end
   end

   // Next state: accept requests in IDLE/DONE, step once per cycle in SHIFT.
   // The reserved op code 2'b10 falls through to the SLL step.
   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      count_d  = count_q;
      op_d     = op_q;
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               op_d     = bus.op;
               result_d = bus.operand;
               count_d  = bus.shamt;
               state_d  = (bus.shamt != '0) ? SHIFT : DONE;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            case (op_q)
               OP_SRL:  result_d = {1'b0, result_q[N-1:1]};
               OP_SRA:  result_d = {result_q[N-1], result_q[N-1:1]};
               default: result_d = {result_q[N-2:0], 1'b0};
            endcase
            count_d = count_q - SW'(1);
            if (count_q == SW'(1)) begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.busy   = (state_q == SHIFT);
   assign bus.done   = (state_q == DONE);
   assign bus.result = result_q;

endmodule

// File: tb/tb_shift_seq.sv
// Randomized scoreboard bench for shift_seq. Stimulus pushes the expected
// result and done cycle into a queue; a monitor on the falling edge pops and
// compares whenever done is seen, and also checks busy and the held result.
module tb_shift_seq;

   localparam int N = 32;

   typedef struct {
      logic [N-1:0] res;
      int           done_at;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   total;
   int   bad;

   exp_t         sb[$];
   int           busy_until;
   bit           active;
   int           cur_e;
   int           cur_sh;
   logic [N-1:0] final_val;

   shift_seq_if #(.N(N)) bus ();

   shift_seq #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts rising edges so expected done cycles can be expressed as edge numbers.
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Shift semantics written directly as arithmetic on the whole word.
   function automatic logic [N-1:0] refShift(input logic [1:0] op, input logic [N-1:0] a, input int sh);
      logic signed [N-1:0] sa;
      sa = $signed(a);
      case (op)
         2'b01:   return a >> sh;
         2'b11:   return N'(sa >>> sh);
         default: return a << sh;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Drives one request for a cycle; sampled on the following rising edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [N-1:0] a, input int sh);
      int e;
      @(posedge clk);
      #1;
      bus.start   = 1'b1;
      bus.op      = op;
      bus.operand = a;
      bus.shamt   = sh[4:0];
      e = cyc + 1;
      if (e > busy_until) begin
         sb.push_back('{res: refShift(op, a, sh), done_at: e + sh});
         busy_until = e + sh;
         cur_e      = e;
         cur_sh     = sh;
         active     = 1'b1;
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
      end
   endtask

   // Asynchronous reset in the middle of a cycle, checked before any clock edge.
   task automatic pulseReset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("async_rst_done", {31'd0, bus.done}, 32'd0);
      checkOutput("async_rst_result", bus.result, 32'd0);
      sb.delete();
      active    = 1'b0;
      final_val = '0;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      rst        = 1'b0;
      busy_until = cyc;
   endtask

   // Monitor: pops the scoreboard on done, checks busy and the held result.
   always @(negedge clk) begin
      logic exp_busy;
      exp_t head;
      if (!rst) begin
         exp_busy = active && (cyc >= cur_e) && (cyc < cur_e + cur_sh);
         checkOutput("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
         if (bus.done) begin
            if (sb.size() == 0) begin
               checkOutput("spurious_done", {31'd0, bus.done}, 32'd0);
            end else begin
               head = sb.pop_front();
               checkOutput("done_cycle", cyc, head.done_at);
               checkOutput("result", bus.result, head.res);
               final_val = head.res;
            end
         end else if (sb.size() != 0 && sb[0].done_at <= cyc) begin
            head = sb.pop_front();
            checkOutput("missed_done", {31'd0, bus.done}, 32'd1);
         end
         if (sb.size() == 0 && !exp_busy) begin
            checkOutput("held_result", bus.result, final_val);
         end
      end
   end

   initial begin
      int op_r;
      int sh_r;
      int gap;
      cyc         = 0;
      total       = 0;
      bad         = 0;
      busy_until  = 0;
      active      = 1'b0;
      cur_e       = 0;
      cur_sh      = 0;
      final_val   = '0;
      rst         = 1'b1;
      bus.start   = 1'b0;
      bus.op      = 2'b00;
      bus.operand = '0;
      bus.shamt   = '0;

      repeat (3) @(posedge clk);
      #2;
      checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
      checkOutput("reset_result", bus.result, 32'd0);
      @(posedge clk);
      #1;
      rst        = 1'b0;
      busy_until = cyc;

      $display("[TB] directed: full-width SLL, SRA/SRL, zero shift");
      applyStimulus(2'b00, 32'h0000_0001, 31);
      idleCycles(34);
      checkOutput("sll31_final", final_val, 32'h8000_0000);
      applyStimulus(2'b11, 32'h8000_00F0, 4);
      idleCycles(7);
      checkOutput("sra4_final", final_val, 32'hF800_000F);
      applyStimulus(2'b01, 32'h8000_00F0, 4);
      idleCycles(7);
      checkOutput("srl4_final", final_val, 32'h0800_000F);
      applyStimulus(2'b01, 32'hDEAD_BEEF, 0);
      idleCycles(3);
      checkOutput("srl0_final", final_val, 32'hDEAD_BEEF);

      $display("[TB] directed: start ignored while shifting, back-to-back in done");
      applyStimulus(2'b00, 32'h0000_0001, 3);
      idleCycles(1);
      applyStimulus(2'b00, 32'h0000_0000, 1);
      applyStimulus(2'b00, 32'h0000_0000, 1);
      applyStimulus(2'b01, 32'h0000_0010, 4);
      idleCycles(8);
      checkOutput("b2b_final", final_val, 32'h0000_0001);

      $display("[TB] directed: reset during a long shift");
      applyStimulus(2'b00, 32'h1234_5678, 20);
      idleCycles(5);
      pulseReset();
      idleCycles(25);
      applyStimulus(2'b10, 32'h0000_0003, 2);
      idleCycles(5);
      checkOutput("after_rst_final", final_val, 32'h0000_000C);

      $display("[TB] random phase");
      for (int i = 0; i < 150; i++) begin
         op_r = $urandom_range(0, 3);
         case ($urandom_range(0, 5))
            0:       sh_r = 0;
            1:       sh_r = 31;
            2:       sh_r = 1;
            default: sh_r = $urandom_range(0, 31);
         endcase
         applyStimulus(op_r[1:0], $urandom, sh_r);
         if ($urandom_range(0, 3) != 0) begin
            gap = $urandom_range(0, sh_r + 3);
            idleCycles(gap);
         end
      end
      idleCycles(1);

      for (int i = 0; i < 100 && sb.size() != 0; i++) begin
         @(posedge clk);
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL drain: %0d results outstanding, expected 0", sb.size());
      end
      @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Overall time bound so the run always reaches its summary.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: cycle %0d reached, expected completion earlier", cyc);
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
